// File: rtl/div_pkg.sv
// ============================================================================
// Module  : div_pkg
// Purpose : Shared definitions for the iterative divider: FSM state encoding,
//           default operand width and iteration-counter sizing.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  // Default operand/result width used by the MIPS datapath.
  localparam int DIV_WIDTH = 32;

  // FSM encoding, 2 bits wide.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // The counter must be able to hold the value WIDTH itself, hence +1.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Purpose : One combinational restoring-division iteration. Shifts the
//           {rem, quo} pair left by one, trial-subtracts the divisor
//           magnitude from the partial remainder and, when the difference is
//           non-negative, keeps it and sets the new quotient LSB.
// Ports   : rem      - partial remainder (WIDTH)
//           quo      - partial quotient / remaining dividend bits (WIDTH)
//           dvs      - divisor magnitude (WIDTH)
//           rem_next - partial remainder after this step (WIDTH)
//           quo_next - partial quotient after this step (WIDTH)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // One extra bit: the shifted remainder can reach 2*dvs-1, and the borrow
  // out of the subtraction is the "negative" indicator.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  always_comb begin
    rem_next = shifted[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule : div_step

`default_nettype wire

// File: rtl/div32_seq.sv
// ============================================================================
// Module  : div32_seq
// Purpose : Iterative restoring divider for MIPS DIV/DIVU. One quotient bit
//           per clock on operand magnitudes, followed by a sign-fix cycle.
//           Results are held until the next sign-fix cycle writes them.
//           Optional macro DIV_EARLY_OUT_EN: a zero divisor or
//           |dividend| < |divisor| skips the iteration phase (done at cycle 2).
// Ports   : clk         - clock, rising edge
//           reset       - asynchronous active-high reset
//           start       - divide request, honoured only when not busy
//           signed_op   - 1 = DIV (two's complement), 0 = DIVU
//           dividend    - numerator, sampled with start (WIDTH)
//           divisor     - denominator, sampled with start (WIDTH)
//           busy        - high while iterating or sign-fixing
//           done        - one-cycle pulse, results valid
//           quotient    - result for LO (WIDTH)
//           remainder   - result for HI (WIDTH)
//           div_by_zero - set with results when divisor was zero
// Parameter: WIDTH (>= 2) operand/result width.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div32_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  div_state_t state;
  div_state_t state_next;

  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             neg_q;
  logic             neg_r;
  logic             dz_q;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  // Operand preparation for an accepted start.
  logic             accept;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] load_val;
  logic             dvs_zero;
  logic             early;

  assign accept   = start && (state == S_IDLE || state == S_DONE);
  assign dvd_neg  = signed_op & dividend[WIDTH-1];
  assign dvs_neg  = signed_op & divisor[WIDTH-1];
  assign dvd_mag  = dvd_neg ? -dividend : dividend;
  assign dvs_mag  = dvs_neg ? -divisor : divisor;
  assign dvs_zero = (divisor == '0);

  // With a zero divisor every trial subtraction succeeds, so the raw
  // dividend loaded here walks unchanged into the remainder register and
  // the quotient fills with ones -- no separate raw-dividend copy needed.
  assign load_val = dvs_zero ? dividend : dvd_mag;

`ifdef DIV_EARLY_OUT_EN
  assign early = dvs_zero || (dvd_mag < dvs_mag);
`else
  assign early = 1'b0;
`endif

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs      (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = early ? S_FIX : S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        // count==1 means this cycle performs the last of WIDTH steps.
        if (count == CNT_W'(1)) begin
          state_next = S_FIX;
        end
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (accept) begin
          state_next = early ? S_FIX : S_RUN;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_q        <= 1'b0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        // Early-out preloads the final {rem, quo} = {|dividend|, 0}.
        rem_q       <= early ? load_val : '0;
        quo_q       <= early ? '0 : load_val;
        dvs_q       <= dvs_mag;
        neg_q       <= dvd_neg ^ dvs_neg;
        neg_r       <= dvd_neg;
        dz_q        <= dvs_zero;
        count       <= CNT_INIT;
        div_by_zero <= 1'b0;
      end else if (state == S_RUN) begin
        rem_q <= step_rem;
        quo_q <= step_quo;
        count <= count - CNT_W'(1);
      end else if (state == S_FIX) begin
        if (dz_q) begin
          quotient    <= '1;
          remainder   <= rem_q;
          div_by_zero <= 1'b1;
        end else begin
          quotient  <= neg_q ? -quo_q : quo_q;
          remainder <= neg_r ? -rem_q : rem_q;
        end
      end
    end
  end

endmodule : div32_seq

`default_nettype wire

// File: tb/tb_div32_seq.sv
// ============================================================================
// Module  : tb_div32_seq
// Purpose : Self-checking bench for div32_seq. Directed cases plus random
//           operands compared against a plain-arithmetic reference model,
//           including latency, busy, divide-by-zero, overflow, ignored start,
//           mid-operation reset and back-to-back operation.
//           Honours DIV_EARLY_OUT_EN when predicting latency.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div32_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  div32_seq #(
    .WIDTH (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: integer division truncating toward zero, remainder sign
  // follows the dividend; zero divisor gives all-ones / raw dividend.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic s, output logic [31:0] q,
                                output logic [31:0] r, output logic z);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      lq = sa / sb;
      lr = sa % sb;
      q  = lq[31:0];
      r  = lr[31:0];
      z  = 1'b0;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b,
                                     input logic s);
    int lat;
    logic [31:0] ma, mb;
    ma  = (s && a[31]) ? (32'd0 - a) : a;
    mb  = (s && b[31]) ? (32'd0 - b) : b;
    lat = 34;
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'd0 || ma < mb) lat = 2;
`else
    if (ma == 32'd0 && mb == 32'd0) lat = 34;
`endif
    return lat;
  endfunction

  // Issue one divide; optionally pulse start again at cycle pulse_at.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic s, input string name, input int pulse_at);
    logic [31:0] eq, er;
    logic        ez;
    int          elat;
    int          cyc;
    bit          busy_bad;
    model(a, b, s, eq, er, ez);
    elat      = exp_latency(a, b, s);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 1;
    busy_bad = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      if (cyc == pulse_at) begin
        start     = 1'b1;
        dividend  = 32'd5;
        divisor   = 32'd1;
        signed_op = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (cyc !== elat) begin
      failures++;
      $display("FAIL %s latency got %0d exp %0d", name, cyc, elat);
    end
    checks++;
    if (busy_bad || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy profile got busy_gap=%0b busy_at_done=%b exp 0/0", name, busy_bad, busy);
    end
    checks++;
    if (quotient !== eq) begin
      failures++;
      $display("FAIL %s quotient got %h exp %h", name, quotient, eq);
    end
    checks++;
    if (remainder !== er) begin
      failures++;
      $display("FAIL %s remainder got %h exp %h", name, remainder, er);
    end
    checks++;
    if (div_by_zero !== ez) begin
      failures++;
      $display("FAIL %s div_by_zero got %b exp %b", name, div_by_zero, ez);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b dz=%b q=%h r=%h exp all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_directed();
    logic [31:0] q_hold;
    run_op(32'd100, 32'd7, 1'b0, "divu_100_7", 0);
    q_hold = quotient;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (quotient !== 32'd14 || q_hold !== 32'd14) begin
      failures++;
      $display("FAIL hold_idle quotient got %h exp %h", quotient, 32'd14);
    end
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2", 0);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, "div_7_m2", 0);
    run_op(32'h0000_1234, 32'd0, 1'b0, "divu_by_zero", 0);
    run_op(32'd9, 32'd3, 1'b0, "divu_9_3_after_dz", 0);
    run_op(32'hFFFF_FF00, 32'd0, 1'b1, "div_neg_by_zero", 0);
  endtask

  task automatic test_overflow_ignore();
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_overflow", 0);
    run_op(32'hDEAD_BEEF, 32'd1234, 1'b0, "ignore_start", 10);
  endtask

  task automatic test_reset_midop();
    bit saw_done;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    signed_op = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      failures++;
      $display("FAIL reset_midop got busy=%b done=%b dz=%b q=%h r=%h exp all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(posedge clk); #1 reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL reset_no_done got activity=1 exp 0");
    end
    run_op(32'd12345, 32'd67, 1'b0, "after_reset", 0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    dividend  = 32'd1000;
    divisor   = 32'd9;
    signed_op = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    // Operands change while busy with start still high: must not be resampled.
    dividend = 32'd50;
    divisor  = 32'd5;
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 34 || quotient !== 32'd111 || remainder !== 32'd1) begin
      failures++;
      $display("FAIL b2b_first got lat=%0d q=%h r=%h exp 34 %h %h", cyc, quotient, remainder, 32'd111, 32'd1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_accept busy got %b exp 1", busy);
    end
    cyc = 1;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc !== 34 || quotient !== 32'd10 || remainder !== 32'd0) begin
      failures++;
      $display("FAIL b2b_second got lat=%0d q=%h r=%h exp 34 %h %h", cyc, quotient, remainder, 32'd10, 32'd0);
    end
    run_op(32'd3, 32'd10, 1'b0, "early_3_10", 0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(0, 15));
        1: a = 32'($urandom_range(0, 255));
        2: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(a, b, s, $sformatf("rand%0d", i), 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_overflow_ignore();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_div32_seq

`default_nettype wire
